// File: rtl/d_ff.sv
// d_ff: positive-edge D flip-flop with asynchronous active-low reset.
// This is the edge-triggered storage element used as the reference for
// latch comparisons. q changes only on a rising clk edge or on reset
// assertion. It is never transparent while clk is high.
// Each bit of d/q is stored independently.
module d_ff #(
    parameter int                     WIDTH       = 1,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d on every rising clk edge. Reset forces RESET_VALUE at once,
    // independent of clk. If reset falls in the same timestep as a rising
    // edge, reset wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: self-checking bench for d_ff. It drives two instances:
// - a 1-bit flip-flop with reset value 0,
// - an 8-bit flip-flop with reset value 8'hA5.
// The reference model records the d value seen at each active rising edge.
// The expected q is the most recent value recorded since the last reset,
// or the reset value if no edge has been recorded since then.
module tb_d_ff;

    localparam logic [7:0] RV8 = 8'hA5;

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [0:0] d1    = 1'b0;
    logic [0:0] q1;
    logic [7:0] d8    = 8'h00;
    logic [7:0] q8;

    // Rising edges fall at 10, 30, 50, ... ns (period 20 ns).
    initial forever #10 clk = ~clk;

    d_ff #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d1),
        .q     (q1)
    );

    d_ff #(.WIDTH(8), .RESET_VALUE(RV8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d8),
        .q     (q8)
    );

    // ---------------- scoreboard / model ----------------
    logic [0:0] exp1_q[$];
    logic [7:0] exp8_q[$];
    int         n_pass   = 0;
    int         n_total  = 0;
    bit         model_on = 1'b0;

    // Record the d value taken at each rising edge while reset is released.
    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            exp1_q.push_back(d1);
            exp8_q.push_back(d8);
        end
    end

    // Reset assertion discards all history, so q goes back to the reset value.
    always @(negedge rst_n) begin
        exp1_q.delete();
        exp8_q.delete();
    end

    function automatic logic [7:0] exp1();
        if (exp1_q.size() == 0) return 8'h00;
        return {7'b0, exp1_q[$]};
    endfunction

    function automatic logic [7:0] exp8();
        if (exp8_q.size() == 0) return RV8;
        return exp8_q[$];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Compare against the model 2 ns after every clk transition. This covers
    // both the high phase and the low phase, so a transparent latch is caught.
    always @(clk) begin
        #2;
        if (model_on) begin
            check("model_q1", {7'b0, q1}, exp1());
            check("model_q8", q8, exp8());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_until(input int t);
        if (time'(t) > $time) #(time'(t) - $time);
    endtask

    task automatic set_d(input logic [0:0] v1, input logic [7:0] v8);
        d1 = v1;
        d8 = v8;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        // Reset asserted before any clock edge; q must load the reset value immediately.
        wait_until(1);  rst_n = 1'b0;
        wait_until(2);  model_on = 1'b1;
                        check("reset_q1", {7'b0, q1}, 8'h00);
                        check("reset_q8", q8, 8'hA5);
        wait_until(3);  set_d(1'b1, 8'hFF);
        wait_until(4);  check("reset_hold_q1", {7'b0, q1}, 8'h00);
                        check("reset_hold_q8", q8, 8'hA5);
                        set_d(1'b0, 8'h00);
        wait_until(5);  rst_n = 1'b1;
        wait_until(6);  check("release_q8", q8, 8'hA5);
        wait_until(12); check("first_cap_q8", q8, 8'h00);

        // Capture with a latency of one edge.
        wait_until(95);  set_d(1'b1, 8'h3C);
        wait_until(105); check("pre_edge_q1", {7'b0, q1}, 8'h00);
        wait_until(112); check("cap_q1", {7'b0, q1}, 8'h01);
                         check("cap_q8", q8, 8'h3C);
        wait_until(195); set_d(1'b0, 8'h3C);
        wait_until(212); check("cap0_q1", {7'b0, q1}, 8'h00);

        // q must hold between edges.
        wait_until(305); d1 = 1'b1;
        wait_until(312); check("hold_a_q1", {7'b0, q1}, 8'h01);
        wait_until(325); d1 = 1'b0;
        wait_until(327); check("hold_b_q1", {7'b0, q1}, 8'h01);
        wait_until(332); check("hold_c_q1", {7'b0, q1}, 8'h00);

        // A narrow pulse that spans an edge is captured for exactly one cycle.
        wait_until(345); d1 = 1'b1;
        wait_until(352); check("span_a_q1", {7'b0, q1}, 8'h01);
        wait_until(355); d1 = 1'b0;
        wait_until(365); check("span_b_q1", {7'b0, q1}, 8'h01);
        wait_until(372); check("span_c_q1", {7'b0, q1}, 8'h00);
        wait_until(385); d1 = 1'b1;
        wait_until(392); check("span_d_q1", {7'b0, q1}, 8'h01);

        // A pulse entirely between two edges is never seen at q.
        wait_until(413); d1 = 1'b0;
        wait_until(432); check("gap_a_q1", {7'b0, q1}, 8'h00);
        wait_until(435); d1 = 1'b1;
        wait_until(442); check("gap_b_q1", {7'b0, q1}, 8'h00);
        wait_until(445); d1 = 1'b0;
        wait_until(452); check("gap_c_q1", {7'b0, q1}, 8'h00);

        // Asynchronous reset in the middle of operation.
        wait_until(455); set_d(1'b1, 8'h5A);
        wait_until(472); check("pre_rst_q8", q8, 8'h5A);
        wait_until(475); rst_n = 1'b0;
        wait_until(476); check("async_q1", {7'b0, q1}, 8'h00);
                         check("async_q8", q8, 8'hA5);
        wait_until(492); check("rst_edge_q8", q8, 8'hA5);
        wait_until(495); rst_n = 1'b1;
        wait_until(497); check("rel_q8", q8, 8'hA5);
        wait_until(512); check("rel_cap_q1", {7'b0, q1}, 8'h01);
                         check("rel_cap_q8", q8, 8'h5A);

        // Reset asserted in the same timestep as a rising edge: reset wins.
        wait_until(530); rst_n = 1'b0;
        wait_until(532); check("coinc_q1", {7'b0, q1}, 8'h00);
                         check("coinc_q8", q8, 8'hA5);
        wait_until(545); rst_n = 1'b1;
        wait_until(552); check("coinc_rel_q8", q8, 8'h5A);

        // Randomized phase. d changes mid-cycle, and there are occasional
        // short reset pulses that contain no clock edge.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #5;
            set_d(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 19) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                check("rnd_rst_q1", {7'b0, q1}, 8'h00);
                check("rnd_rst_q8", q8, 8'hA5);
                #1 rst_n = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
                // Extra d activity inside the same cycle; only the value at the edge counts.
                #6;
                set_d(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end
        end

        @(posedge clk);
        #5;
        model_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
